// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl_pkg
// Brief   : Shared state and command encodings for the counter sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Command opcodes as carried on cmd_op
    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_START = 2'd1,
        OP_STOP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_t;

endpackage
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// Module  : counter_core
// Brief   : WIDTH-bit up-counter datapath with synchronous clear and enable.
//           Clear takes priority over enable.
// Revision: 1.0 - initial release
// ============================================================================
module counter_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: clear wins, otherwise increment when enabled
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    // Count register, asynchronously cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl
// Brief   : Command-driven sequencer for an up-counter. Accepts LOAD/START/
//           STOP/CLEAR over valid/ready, runs one-shot or periodic up to a
//           programmable terminal value, reports tc/busy/done/cmd_err.
// Revision: 1.0 - initial release
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             periodic,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] term_q,  term_d;
    logic             mode_q,  mode_d;     // 1 = periodic
    logic             ready_q, ready_d;
    logic             err_q,   err_d;

    logic             core_clr;
    logic             core_en;
    logic             accept;
    logic             at_term;
    cmd_op_t          op;
    logic [WIDTH-1:0] count;

    assign op      = cmd_op_t'(cmd_op);
    assign accept  = cmd_valid && ready_q;
    assign at_term = (count == term_q);

    // Next-state, register updates and counter controls for one cycle
    always_comb begin
        state_d  = state_q;
        term_d   = term_q;
        mode_d   = mode_q;
        ready_d  = !accept;          // one dead cycle after every acceptance
        err_d    = 1'b0;
        core_clr = 1'b0;
        core_en  = 1'b0;

        if (accept && (op == OP_CLEAR)) begin
            // CLEAR overrides counting and any terminal-count action
            state_d  = IDLE;
            core_clr = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // Autonomous counting step
                    if (!at_term) begin
                        core_en = 1'b1;
                    end else if (mode_q) begin
                        core_clr = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                    if (accept) begin
                        case (op)
                            OP_STOP: begin
                                // One-shot terminal count: DONE wins, STOP is absorbed
                                if (!(at_term && !mode_q)) begin
                                    state_d = PAUSE;
                                    core_en = 1'b0;   // hold q; a wrap still clears
                                end
                            end
                            OP_LOAD, OP_START: err_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // IDLE, PAUSE, DONE: counter is frozen
                    if (accept) begin
                        case (op)
                            OP_LOAD:  term_d = cmd_data;
                            OP_START: begin
                                state_d = RUN;
                                if (state_q != PAUSE) begin
                                    core_clr = 1'b1;
                                    mode_d   = periodic;
                                end
                            end
                            OP_STOP:  err_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            term_q  <= '1;
            mode_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (core_clr),
        .en    (core_en),
        .q     (count)
    );

    assign q         = count;
    assign tc        = (state_q == RUN) && at_term;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign done      = (state_q == DONE);
    assign cmd_ready = ready_q;
    assign cmd_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_ctrl
// Brief   : Self-checking bench for counter_ctrl (WIDTH=4): directed scenarios
//           followed by random commands, compared against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         periodic;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
    logic         cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_state, m_q, m_term;
    bit m_mode, m_ready, m_err;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .periodic  (periodic),
        .q         (q),
        .tc        (tc),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_q = 0; m_term = (1 << W) - 1;
        m_mode = 1'b0; m_ready = 1'b1; m_err = 1'b0;
    endtask

    // One clock of the sequencer described in plain terms
    task automatic model_step(input bit v, input int op, input int data, input bit per);
        bit acc  = v && m_ready;
        bit at_t = (m_state == M_RUN) && (m_q == m_term);
        int ns   = m_state;
        int nq   = m_q;
        int nt   = m_term;
        bit nm   = m_mode;
        bit e    = 1'b0;
        if (acc && op == 3) begin
            ns = M_IDLE; nq = 0;
        end else begin
            if (m_state == M_RUN) begin
                if (!at_t)       nq = m_q + 1;
                else if (m_mode) nq = 0;
                else             ns = M_DONE;
            end
            if (acc) begin
                if (op == 0) begin
                    if (m_state == M_RUN) e = 1'b1; else nt = data;
                end else if (op == 1) begin
                    if (m_state == M_RUN) e = 1'b1;
                    else begin
                        ns = M_RUN;
                        if (m_state != M_PAUSE) begin nq = 0; nm = per; end
                    end
                end else if (op == 2) begin
                    if (m_state != M_RUN) e = 1'b1;
                    else if (!(at_t && !m_mode)) begin
                        ns = M_PAUSE;
                        nq = at_t ? 0 : m_q;
                    end
                end
            end
        end
        m_state = ns; m_q = nq; m_term = nt; m_mode = nm;
        m_ready = !acc; m_err = e;
    endtask

    task automatic compare_all();
        check("q",         int'(q),         m_q);
        check("tc",        int'(tc),        int'((m_state == M_RUN) && (m_q == m_term)));
        check("busy",      int'(busy),      int'(m_state == M_RUN || m_state == M_PAUSE));
        check("done",      int'(done),      int'(m_state == M_DONE));
        check("cmd_ready", int'(cmd_ready), int'(m_ready));
        check("cmd_err",   int'(cmd_err),   int'(m_err));
    endtask

    // Drive inputs on the falling edge, step model on the rising edge, compare 1ns later
    task automatic cycle(input bit v, input int op, input int data, input bit per);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op[1:0];
        cmd_data  = data[W-1:0];
        periodic  = per;
        @(posedge clk);
        model_step(v, op, data, per);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic send(input int op, input int data, input bit per);
        if (!m_ready) idle();
        cycle(1'b1, op, data, per);
    endtask

    // Step until the model is running with the given count (pre-edge), bounded
    task automatic wait_q(input int target);
        int n = 0;
        while (!(m_state == M_RUN && m_q == target) && n < 40) begin
            idle();
            n++;
        end
        if (n >= 40) check("wait_q_timeout", m_q, target);
    endtask

    initial begin
        int errs;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; periodic = 1'b0;
        model_reset();

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_err", int'(cmd_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // One-shot to 5
        send(0, 5, 1'b0);
        cycle(1'b1, 1, 0, 1'b0);              // ignored: ready is low
        check("ignored_ready_back", int'(cmd_ready), 1);
        send(1, 0, 1'b0);
        check("os_q0", int'(q), 0);
        check("os_tc0", int'(tc), 0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            check("os_q", int'(q), i);
            check("os_tc", int'(tc), (i == 5) ? 1 : 0);
        end
        idle();
        check("os_done", int'(done), 1);
        check("os_busy", int'(busy), 0);
        idle();
        check("os_hold", int'(q), 5);

        // Periodic, term 3
        send(0, 3, 1'b0);
        send(1, 0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            idle();
            check("per_q", int'(q), i % 4);
            check("per_tc", int'(tc), (i % 4 == 3) ? 1 : 0);
            check("per_done", int'(done), 0);
        end

        // STOP at q=2, hold, resume
        wait_q(2);
        send(2, 0, 1'b0);
        check("pause_q", int'(q), 2);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("pause_hold", int'(q), 2);
            check("pause_busy", int'(busy), 1);
        end
        send(1, 0, 1'b0);
        check("resume_q", int'(q), 2);
        idle();
        check("resume_q3", int'(q), 3);

        // Back-to-back with illegal LOAD during RUN
        errs = 0;
        cycle(1'b1, 0, 7, 1'b0);
        check("b2b_ready0", int'(cmd_ready), 0);
        errs += int'(cmd_err);
        cycle(1'b1, 2, 0, 1'b0);
        check("b2b_ready1", int'(cmd_ready), 1);
        errs += int'(cmd_err);
        cycle(1'b1, 2, 0, 1'b0);
        check("b2b_ready2", int'(cmd_ready), 0);
        errs += int'(cmd_err);
        idle();
        errs += int'(cmd_err);
        check("b2b_err_pulses", errs, 1);
        send(1, 0, 1'b0);
        wait_q(3);
        idle();
        check("term_kept", int'(q), 0);

        // STOP coinciding with periodic wrap
        wait_q(3);
        check("wrap_tc", int'(tc), 1);
        send(2, 0, 1'b0);
        check("wrap_stop_q", int'(q), 0);
        check("wrap_stop_busy", int'(busy), 1);
        check("wrap_stop_tc", int'(tc), 0);
        idle();
        check("wrap_stop_hold", int'(q), 0);

        // Terminal value 0
        send(0, 0, 1'b0);
        send(3, 0, 1'b0);
        send(1, 0, 1'b1);
        check("t0p_tc", int'(tc), 1);
        idle();
        check("t0p_tc2", int'(tc), 1);
        check("t0p_q", int'(q), 0);
        send(3, 0, 1'b0);
        send(1, 0, 1'b0);
        check("t0o_tc", int'(tc), 1);
        idle();
        check("t0o_done", int'(done), 1);

        // Asynchronous reset mid-cycle at q=2
        send(0, 4, 1'b0);
        send(1, 0, 1'b0);
        wait_q(2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_tc", int'(tc), 0);
        check("arst_ready", int'(cmd_ready), 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();
        check("arst_no_resume", int'(q), 0);
        send(1, 0, 1'b0);
        for (int i = 0; i < 16; i++) idle();
        check("arst_term_full", int'(q), 15);
        check("arst_term_done", int'(done), 1);

        // Random commands against the model
        for (int i = 0; i < 400; i++) begin
            int r  = $urandom_range(0, 9);
            int op = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            int d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
            bit v  = ($urandom_range(0, 3) == 0);
            cycle(v, op, d, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
